// File: rtl/tlb_ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ptw_pkg
// Description : Shared walker definitions: state encoding, PTE field
//               positions, page-offset width and PTE address helper.
// Revision    : 1.0  initial release
// ============================================================================
package tlb_ptw_pkg;

    localparam int unsigned c_page_offset_w = 12;
    localparam int unsigned c_pte_v         = 0;
    localparam int unsigned c_pte_r         = 1;
    localparam int unsigned c_pte_w         = 2;
    localparam int unsigned c_pte_x         = 3;
    localparam int unsigned c_pte_ppn_lsb   = 10;
    localparam int unsigned c_pte_ppn_msb   = 29;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L0_REQ  = 3'd3,
        ST_L0_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } ptw_state_e;

    // Byte address of the 4-byte PTE at index idx of the table at page ppn.
    function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [9:0] idx);
        return {ppn, {c_page_offset_w{1'b0}}} + {20'b0, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_pte_decode.sv
`default_nettype none
// ============================================================================
// Module      : tlb_pte_decode
// Description : Combinational PTE field decoder shared by both walk levels.
// Revision    : 1.0  initial release
// ============================================================================
module tlb_pte_decode
    import tlb_ptw_pkg::*;
(
    input  logic [31:0] pte,
    output logic        valid,
    output logic        leaf,
    output logic        fault,
    output logic [19:0] ppn,
    output logic [2:0]  perm
);

    logic w_r;
    logic w_w;
    logic w_x;
    logic w_unused;

    assign w_r      = pte[c_pte_r];
    assign w_w      = pte[c_pte_w];
    assign w_x      = pte[c_pte_x];
    assign valid    = pte[c_pte_v];
    assign leaf     = valid & (w_r | w_x);
    // Writable-but-not-readable is a reserved encoding.
    assign fault    = ~valid | (w_w & ~w_r);
    assign ppn      = pte[c_pte_ppn_msb:c_pte_ppn_lsb];
    assign perm     = {w_x, w_w, w_r};
    assign w_unused = ^{pte[31:30], pte[9:4]};

endmodule
`default_nettype wire

// File: rtl/tlb_ptw.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ptw
// Description : Two-level Sv32-style page-table walker with registered outputs.
//               Define TLB_PTW_SUPERPAGE_EN to accept aligned L1 leaf PTEs.
// Revision    : 1.0  initial release
// ============================================================================
module tlb_ptw
    import tlb_ptw_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] satp_ppn_i,
    input  logic        ptw_req_valid_i,
    output logic        ptw_req_ready_o,
    input  logic [19:0] ptw_req_vpn_i,
    output logic        ptw_resp_valid_o,
    input  logic        ptw_resp_ready_i,
    output logic [19:0] ptw_resp_ppn_o,
    output logic [2:0]  ptw_resp_perm_o,
    output logic        ptw_resp_fault_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
);

    ptw_state_e  r_state,      w_state_nxt;
    logic [9:0]  r_vpn0,       w_vpn0_nxt;
    logic        r_req_ready,  w_req_ready_nxt;
    logic        r_mem_valid,  w_mem_valid_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [19:0] r_resp_ppn,   w_resp_ppn_nxt;
    logic [2:0]  r_resp_perm,  w_resp_perm_nxt;
    logic        r_resp_fault, w_resp_fault_nxt;

    logic        w_pte_valid;
    logic        w_pte_leaf;
    logic        w_pte_fault;
    logic [19:0] w_pte_ppn;
    logic [2:0]  w_pte_perm;

    tlb_pte_decode u_pte_decode (
        .pte   (mem_resp_data_i),
        .valid (w_pte_valid),
        .leaf  (w_pte_leaf),
        .fault (w_pte_fault),
        .ppn   (w_pte_ppn),
        .perm  (w_pte_perm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vpn0       <= '0;
            r_req_ready  <= 1'b1;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_ppn   <= '0;
            r_resp_perm  <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vpn0       <= w_vpn0_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_ppn   <= w_resp_ppn_nxt;
            r_resp_perm  <= w_resp_perm_nxt;
            r_resp_fault <= w_resp_fault_nxt;
        end
    end

    // The root PPN is captured directly into the L1 address register on accept.
    always_comb begin
        w_state_nxt      = r_state;
        w_vpn0_nxt       = r_vpn0;
        w_req_ready_nxt  = r_req_ready;
        w_mem_valid_nxt  = r_mem_valid;
        w_mem_addr_nxt   = r_mem_addr;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_ppn_nxt   = r_resp_ppn;
        w_resp_perm_nxt  = r_resp_perm;
        w_resp_fault_nxt = r_resp_fault;
        case (r_state)
            ST_IDLE: begin
                if (ptw_req_valid_i) begin
                    w_state_nxt     = ST_L1_REQ;
                    w_vpn0_nxt      = ptw_req_vpn_i[9:0];
                    w_req_ready_nxt = 1'b0;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_addr_nxt  = pte_addr(satp_ppn_i, ptw_req_vpn_i[19:10]);
                end
            end
            ST_L1_REQ: begin
                if (mem_req_ready_i) begin
                    w_state_nxt     = ST_L1_WAIT;
                    w_mem_valid_nxt = 1'b0;
                end
            end
            ST_L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    w_state_nxt      = ST_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_fault_nxt = 1'b1;
                    w_resp_ppn_nxt   = '0;
                    w_resp_perm_nxt  = '0;
                    if (w_pte_fault) begin
                        w_resp_fault_nxt = 1'b1;
                    end else if (w_pte_valid && !w_pte_leaf) begin
                        w_state_nxt      = ST_L0_REQ;
                        w_resp_valid_nxt = 1'b0;
                        w_resp_fault_nxt = 1'b0;
                        w_mem_valid_nxt  = 1'b1;
                        w_mem_addr_nxt   = pte_addr(w_pte_ppn, r_vpn0);
                    end else begin
`ifdef TLB_PTW_SUPERPAGE_EN
                        // A superpage must be aligned to 1024 base pages.
                        if (w_pte_ppn[9:0] == 10'd0) begin
                            w_resp_fault_nxt = 1'b0;
                            w_resp_ppn_nxt   = {w_pte_ppn[19:10], r_vpn0};
                            w_resp_perm_nxt  = w_pte_perm;
                        end
`else
                        w_resp_fault_nxt = 1'b1;
`endif
                    end
                end
            end
            ST_L0_REQ: begin
                if (mem_req_ready_i) begin
                    w_state_nxt     = ST_L0_WAIT;
                    w_mem_valid_nxt = 1'b0;
                end
            end
            ST_L0_WAIT: begin
                if (mem_resp_valid_i) begin
                    w_state_nxt      = ST_RESP;
                    w_resp_valid_nxt = 1'b1;
                    if (w_pte_fault || !w_pte_leaf) begin
                        w_resp_fault_nxt = 1'b1;
                        w_resp_ppn_nxt   = '0;
                        w_resp_perm_nxt  = '0;
                    end else begin
                        w_resp_fault_nxt = 1'b0;
                        w_resp_ppn_nxt   = w_pte_ppn;
                        w_resp_perm_nxt  = w_pte_perm;
                    end
                end
            end
            ST_RESP: begin
                if (ptw_resp_ready_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_req_ready_nxt  = 1'b1;
                w_mem_valid_nxt  = 1'b0;
                w_resp_valid_nxt = 1'b0;
            end
        endcase
    end

    assign ptw_req_ready_o  = r_req_ready;
    assign mem_req_valid_o  = r_mem_valid;
    assign mem_req_addr_o   = r_mem_addr;
    assign ptw_resp_valid_o = r_resp_valid;
    assign ptw_resp_ppn_o   = r_resp_ppn;
    assign ptw_resp_perm_o  = r_resp_perm;
    assign ptw_resp_fault_o = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_tlb_ptw.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_ptw
// Description : Self-checking bench for tlb_ptw with a behavioural walk model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] satp_ppn_i = '0;
    logic        ptw_req_valid_i = 1'b0;
    logic        ptw_req_ready_o;
    logic [19:0] ptw_req_vpn_i = '0;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i = 1'b0;
    logic [19:0] ptw_resp_ppn_o;
    logic [2:0]  ptw_resp_perm_o;
    logic        ptw_resp_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;

    always #5 clk = ~clk;

    tlb_ptw dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .satp_ppn_i       (satp_ppn_i),
        .ptw_req_valid_i  (ptw_req_valid_i),
        .ptw_req_ready_o  (ptw_req_ready_o),
        .ptw_req_vpn_i    (ptw_req_vpn_i),
        .ptw_resp_valid_o (ptw_resp_valid_o),
        .ptw_resp_ready_i (ptw_resp_ready_i),
        .ptw_resp_ppn_o   (ptw_resp_ppn_o),
        .ptw_resp_perm_o  (ptw_resp_perm_o),
        .ptw_resp_fault_o (ptw_resp_fault_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i)
    );

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] addr_log[$];
    logic [31:0] stall_addrs[$];
    int          stall_cnt = 0;
    int          resp_delay = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    // Memory: accepts requests (optionally stalled), answers after 1+resp_delay cycles.
    initial begin
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_valid_i = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid_i = 1'b1;
                    mem_resp_data_i  = pend_data;
                end
            end
            if (mem_req_valid_o === 1'b1 && stall_cnt > 0) begin
                mem_req_ready_i = 1'b0;
                stall_cnt--;
                stall_addrs.push_back(mem_req_addr_o);
            end else begin
                mem_req_ready_i = 1'b1;
            end
            if (mem_req_valid_o === 1'b1 && mem_req_ready_i) begin
                addr_log.push_back(mem_req_addr_o);
                pend_data = mem_rd(mem_req_addr_o);
                pend_cnt  = 1 + resp_delay;
            end
        end
    end

    always @(negedge clk) begin
        if (ptw_req_ready_o === 1'b1 && ptw_resp_valid_o === 1'b1) begin
            miscompares++;
            $display("FAIL ready_valid_exclusive: ready=%b valid=%b, required never both 1",
                     ptw_req_ready_o, ptw_resp_valid_o);
        end
    end

    // Reference walk computed straight from the page-table rules.
    task automatic model_walk(input logic [19:0] satp, input logic [19:0] vpn,
                              output logic [19:0] ppn, output logic [2:0] perm,
                              output logic fault, output int reads,
                              output logic [31:0] a1, output logic [31:0] a0);
        logic [31:0] pte;
        logic [31:0] p_ppn;
        ppn = '0; perm = '0; fault = 1'b1; a0 = '0;
        a1 = {12'h0, satp} * 32'd4096 + {12'h0, vpn} / 32'd1024 * 32'd4;
        pte = mem_rd(a1);
        reads = 1;
        p_ppn = (pte / 32'd1024) % 32'h100000;
        if (pte[0] == 1'b0 || (pte[2] && !pte[1])) begin
            fault = 1'b1;
        end else if (!pte[1] && !pte[3]) begin
            a0 = p_ppn * 32'd4096 + ({12'h0, vpn} % 32'd1024) * 32'd4;
            pte = mem_rd(a0);
            reads = 2;
            p_ppn = (pte / 32'd1024) % 32'h100000;
            if (pte[0] == 1'b1 && !(pte[2] && !pte[1]) && (pte[1] || pte[3])) begin
                fault = 1'b0;
                ppn   = p_ppn[19:0];
                perm  = {pte[3], pte[2], pte[1]};
            end
        end else begin
`ifdef TLB_PTW_SUPERPAGE_EN
            if (p_ppn % 32'd1024 == 0) begin
                p_ppn = p_ppn + {12'h0, vpn} % 32'd1024;
                fault = 1'b0;
                ppn   = p_ppn[19:0];
                perm  = {pte[3], pte[2], pte[1]};
            end
`endif
        end
    endtask

    // Drives one request and collects what the walker did; callers compare.
    task automatic run_walk(input logic [19:0] satp, input logic [19:0] vpn, input int hold,
                            output int lat, output logic [19:0] ppn, output logic [2:0] perm,
                            output logic fault, output logic stable, output logic after_ok,
                            output logic timeout);
        int guard;
        lat = 0; ppn = '0; perm = '0; fault = 1'b0;
        stable = 1'b1; after_ok = 1'b0; timeout = 1'b0;
        addr_log.delete();
        guard = 0;
        while (ptw_req_ready_o !== 1'b1 && guard < 50) begin
            @(posedge clk); #2; guard++;
        end
        if (guard >= 50) begin timeout = 1'b1; return; end
        satp_ppn_i = satp; ptw_req_vpn_i = vpn; ptw_req_valid_i = 1'b1;
        @(posedge clk); #2;
        ptw_req_valid_i = 1'b0;
        satp_ppn_i    = 20'($urandom);
        ptw_req_vpn_i = 20'($urandom);
        lat = 1;
        while (ptw_resp_valid_o !== 1'b1 && lat < 60) begin
            @(posedge clk); #2; lat++;
        end
        if (lat >= 60) begin timeout = 1'b1; return; end
        ppn = ptw_resp_ppn_o; perm = ptw_resp_perm_o; fault = ptw_resp_fault_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            if (ptw_resp_valid_o !== 1'b1 || ptw_resp_ppn_o !== ppn || ptw_resp_perm_o !== perm ||
                ptw_resp_fault_o !== fault || ptw_req_ready_o !== 1'b0)
                stable = 1'b0;
        end
        ptw_resp_ready_i = 1'b1;
        @(posedge clk); #2;
        ptw_resp_ready_i = 1'b0;
        after_ok = (ptw_resp_valid_o === 1'b0 && ptw_req_ready_o === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({ptw_req_ready_o, mem_req_valid_o, ptw_resp_valid_o, ptw_resp_fault_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: rdy/mvld/rvld/flt=%b required 1000",
                     {ptw_req_ready_o, mem_req_valid_o, ptw_resp_valid_o, ptw_resp_fault_o});
        end
        vectors++;
        if ({mem_req_addr_o, ptw_resp_ppn_o, ptw_resp_perm_o} !== 55'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h ppn=%h perm=%b required all 0",
                     mem_req_addr_o, ptw_resp_ppn_o, ptw_resp_perm_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_four_kib_walk();
        int lat; logic [19:0] ppn; logic [2:0] perm; logic flt, stb, aft, to;
        mem_model.delete();
        mem_model[32'h0001_0120] = 32'h0000_8001;
        mem_model[32'h0002_0D14] = 32'h2AF3_7807;
        run_walk(20'h00010, 20'h12345, 0, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (to !== 1'b0 || lat != 5) begin
            miscompares++; $display("FAIL 4k_latency: timeout=%b lat=%0d required lat 5", to, lat);
        end
        vectors++;
        if (addr_log.size() != 2 || addr_log[0] !== 32'h0001_0120 || addr_log[1] !== 32'h0002_0D14) begin
            miscompares++;
            $display("FAIL 4k_addrs: reads=%0d first=%h required 2 reads 00010120,00020d14",
                     addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 32'h0);
        end
        vectors++;
        if (ppn !== 20'hABCDE || perm !== 3'b011 || flt !== 1'b0 || aft !== 1'b1) begin
            miscompares++;
            $display("FAIL 4k_result: ppn=%h perm=%b fault=%b after=%b required abcde 011 0 1",
                     ppn, perm, flt, aft);
        end
    endtask

    task automatic test_superpage();
        int lat; logic [19:0] ppn; logic [2:0] perm; logic flt, stb, aft, to;
        logic [19:0] e_ppn; logic [2:0] e_perm; logic e_flt;
`ifdef TLB_PTW_SUPERPAGE_EN
        e_ppn = 20'h40345; e_perm = 3'b101; e_flt = 1'b0;
`else
        e_ppn = 20'h0; e_perm = 3'b000; e_flt = 1'b1;
`endif
        mem_model.delete();
        mem_model[32'h0001_0120] = 32'h1000_000B;
        run_walk(20'h00010, 20'h12345, 0, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (to !== 1'b0 || lat != 3 || addr_log.size() != 1) begin
            miscompares++;
            $display("FAIL superpage_timing: lat=%0d reads=%0d required lat 3, 1 read", lat, addr_log.size());
        end
        vectors++;
        if (ppn !== e_ppn || perm !== e_perm || flt !== e_flt) begin
            miscompares++;
            $display("FAIL superpage_result: ppn=%h perm=%b fault=%b required %h %b %b",
                     ppn, perm, flt, e_ppn, e_perm, e_flt);
        end
    endtask

    task automatic test_l1_faults();
        int lat; logic [19:0] ppn; logic [2:0] perm; logic flt, stb, aft, to;
        mem_model.delete();
        mem_model[32'h0001_0120] = 32'h1000_040B;
        run_walk(20'h00010, 20'h12345, 0, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (lat != 3 || flt !== 1'b1 || ppn !== 20'h0 || perm !== 3'b000) begin
            miscompares++;
            $display("FAIL misaligned_leaf: lat=%0d fault=%b ppn=%h perm=%b required 3 1 0 0",
                     lat, flt, ppn, perm);
        end
        mem_model.delete();
        run_walk(20'h00010, 20'h12345, 0, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (to !== 1'b0 || lat != 3 || flt !== 1'b1 || addr_log.size() != 1) begin
            miscompares++;
            $display("FAIL invalid_l1: lat=%0d fault=%b reads=%0d required 3 1 1",
                     lat, flt, addr_log.size());
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [19:0] ppn; logic [2:0] perm; logic flt, stb, aft, to;
        logic extra;
        mem_model.delete();
        mem_model[32'h0001_0120] = 32'h0000_8001;
        mem_model[32'h0002_0D14] = 32'h2AF3_7807;
        stall_addrs.delete();
        stall_cnt = 3;
        run_walk(20'h00010, 20'h12345, 2, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (stall_addrs.size() != 3 || stall_addrs[0] !== 32'h0001_0120 ||
            stall_addrs[2] !== 32'h0001_0120 || addr_log.size() != 2 || addr_log[0] !== 32'h0001_0120) begin
            miscompares++;
            $display("FAIL stall_addr_hold: stalls=%0d reads=%0d required 3 stalls at 00010120 then fire",
                     stall_addrs.size(), addr_log.size());
        end
        vectors++;
        if (lat != 8 || stb !== 1'b1 || aft !== 1'b1) begin
            miscompares++;
            $display("FAIL resp_hold: lat=%0d stable=%b after=%b required 8 1 1", lat, stb, aft);
        end
        vectors++;
        if (ppn !== 20'hABCDE || perm !== 3'b011 || flt !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_result: ppn=%h perm=%b fault=%b required abcde 011 0", ppn, perm, flt);
        end
        extra = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
            if (ptw_resp_valid_o !== 1'b0) extra = 1'b1;
        end
        vectors++;
        if (extra !== 1'b0) begin
            miscompares++; $display("FAIL single_response: extra_valid=%b required 0", extra);
        end
    endtask

    task automatic test_reset_midwalk();
        int lat, guard; logic [19:0] ppn; logic [2:0] perm; logic flt, stb, aft, to;
        logic leak;
        mem_model.delete();
        mem_model[32'h0001_0120] = 32'h0000_8001;
        mem_model[32'h0002_0D14] = 32'h2AF3_7807;
        addr_log.delete();
        resp_delay = 3;
        satp_ppn_i = 20'h00010; ptw_req_vpn_i = 20'h12345; ptw_req_valid_i = 1'b1;
        @(posedge clk); #2;
        ptw_req_valid_i = 1'b0;
        guard = 0;
        while (addr_log.size() < 2 && guard < 30) begin
            @(posedge clk); #2; guard++;
        end
        vectors++;
        if (addr_log.size() != 2) begin
            miscompares++; $display("FAIL midwalk_l0_issue: reads=%0d required 2", addr_log.size());
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        leak = 1'b0;
        repeat (8) begin
            @(posedge clk); #2;
            if (ptw_resp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || ptw_req_ready_o !== 1'b1)
                leak = 1'b1;
        end
        vectors++;
        if (leak !== 1'b0) begin
            miscompares++; $display("FAIL midwalk_abandon: activity_after_reset=%b required 0", leak);
        end
        resp_delay = 0;
        run_walk(20'h00010, 20'h12345, 0, lat, ppn, perm, flt, stb, aft, to);
        vectors++;
        if (to !== 1'b0 || lat != 5 || ppn !== 20'hABCDE || perm !== 3'b011 || flt !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_walk: lat=%0d ppn=%h perm=%b fault=%b required 5 abcde 011 0",
                     lat, ppn, perm, flt);
        end
    endtask

    function automatic logic [31:0] rand_pte(input int kind, input logic aligned);
        logic [31:0] p;
        logic [2:0]  leaf_rwx [5];
        leaf_rwx = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b100};
        p = $urandom;
        if (aligned) p[19:10] = 10'h0;
        case (kind)
            0:       p[0] = 1'b0;
            1:       p[3:0] = 4'b0001;
            2:       begin p[0] = 1'b1; p[3:1] = leaf_rwx[$urandom_range(0, 4)]; end
            default: begin p[0] = 1'b1; p[2:1] = 2'b10; end
        endcase
        return p;
    endfunction

    task automatic test_random();
        int lat, reads; logic [19:0] ppn, e_ppn, satp, vpn; logic [2:0] perm, e_perm;
        logic flt, e_flt, stb, aft, to; logic [31:0] a1, a0, p1, l0a;
        int kinds [6];
        kinds = '{0, 1, 1, 2, 2, 3};
        for (int n = 0; n < 40; n++) begin
            satp = 20'($urandom);
            vpn  = 20'($urandom);
            mem_model.delete();
            l0a = {satp, 12'h0} + {20'h0, vpn[19:10], 2'b00};
            p1  = rand_pte(kinds[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            mem_model[l0a] = p1;
            mem_model[{p1[29:10], 12'h0} + {20'h0, vpn[9:0], 2'b00}] =
                rand_pte(kinds[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            model_walk(satp, vpn, e_ppn, e_perm, e_flt, reads, a1, a0);
            run_walk(satp, vpn, $urandom_range(0, 2), lat, ppn, perm, flt, stb, aft, to);
            vectors++;
            if (to !== 1'b0 || ppn !== e_ppn || perm !== e_perm || flt !== e_flt) begin
                miscompares++;
                $display("FAIL random_result[%0d]: ppn=%h perm=%b fault=%b required %h %b %b",
                         n, ppn, perm, flt, e_ppn, e_perm, e_flt);
            end
            vectors++;
            if (lat != (reads == 2 ? 5 : 3) || addr_log.size() != reads || addr_log[0] !== a1 ||
                (reads == 2 && addr_log[1] !== a0) || stb !== 1'b1 || aft !== 1'b1) begin
                miscompares++;
                $display("FAIL random_timing[%0d]: lat=%0d reads=%0d stable=%b after=%b required reads %0d",
                         n, lat, addr_log.size(), stb, aft, reads);
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_kib_walk();
        test_superpage();
        test_l1_faults();
        test_backpressure();
        test_reset_midwalk();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
